// File: rtl/alu_uart_master.sv
// Sends operand A, operand B and the opcode to a remote ALU through a UART TX FIFO and returns its result byte.
// Optional response timeout is built when ALU_MASTER_TIMEOUT_EN is defined.
module alu_uart_master #(
    parameter int NB_DATA       = 8,
    parameter int NB_OPCODE     = 6,
    parameter int NB_TIMEOUT    = 24,
    parameter int TIMEOUT_LIMIT = 10_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [NB_DATA-1:0]   i_op_A,
    input  logic [NB_DATA-1:0]   i_op_B,
    input  logic [NB_OPCODE-1:0] i_opcode,
    input  logic                 i_fifo_tx_full,
    output logic                 o_fifo_tx_write,
    output logic [NB_DATA-1:0]   o_data_to_write,
    input  logic                 i_fifo_rx_empty,
    output logic                 o_fifo_rx_read,
    input  logic [NB_DATA-1:0]   i_data_to_read,
    output logic                 o_rsp_valid,
    output logic [NB_DATA-1:0]   o_rsp_result,
    output logic                 o_rsp_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        SEND_OP,
        WAIT_RSP,
        DONE
    } state_t;

    state_t                 state_reg, state_next;
    logic [NB_DATA-1:0]     a_reg, a_next;
    logic [NB_DATA-1:0]     b_reg, b_next;
    logic [NB_OPCODE-1:0]   op_reg, op_next;
    logic [NB_DATA-1:0]     result_reg, result_next;
    logic                   rx_read_comb;

`ifdef ALU_MASTER_TIMEOUT_EN
    localparam logic [NB_TIMEOUT-1:0] LIMIT_M1 = NB_TIMEOUT'(TIMEOUT_LIMIT - 1);

    logic [NB_TIMEOUT-1:0]  count_reg, count_next;
    logic                   timeout_reg, timeout_next;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            count_reg   <= count_next;
            timeout_reg <= timeout_next;
        end
    end

    assign o_rsp_timeout = (state_reg == DONE) && timeout_reg;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{32'(NB_TIMEOUT), 32'(TIMEOUT_LIMIT)};
    assign o_rsp_timeout      = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            op_reg     <= op_next;
            result_reg <= result_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        a_next          = a_reg;
        b_next          = b_reg;
        op_next         = op_reg;
        result_next     = result_reg;
        o_fifo_tx_write = 1'b0;
        o_data_to_write = '0;
        rx_read_comb    = 1'b0;
`ifdef ALU_MASTER_TIMEOUT_EN
        count_next      = count_reg;
        timeout_next    = timeout_reg;
`endif
        case (state_reg)
            IDLE: begin
                // Stale bytes (e.g. a late answer to an aborted request) are flushed before accepting.
                if (!i_fifo_rx_empty) begin
                    rx_read_comb = 1'b1;
                end else if (i_req_valid) begin
                    a_next     = i_op_A;
                    b_next     = i_op_B;
                    op_next    = i_opcode;
                    state_next = SEND_A;
                end
            end
            SEND_A: begin
                o_data_to_write = a_reg;
                if (!i_fifo_tx_full) begin
                    o_fifo_tx_write = 1'b1;
                    state_next      = SEND_B;
                end
            end
            SEND_B: begin
                o_data_to_write = b_reg;
                if (!i_fifo_tx_full) begin
                    o_fifo_tx_write = 1'b1;
                    state_next      = SEND_OP;
                end
            end
            SEND_OP: begin
                o_data_to_write = NB_DATA'(op_reg);
                if (!i_fifo_tx_full) begin
                    o_fifo_tx_write = 1'b1;
                    state_next      = WAIT_RSP;
`ifdef ALU_MASTER_TIMEOUT_EN
                    count_next      = '0;
`endif
                end
            end
            WAIT_RSP: begin
                if (!i_fifo_rx_empty) begin
                    result_next  = i_data_to_read;
                    rx_read_comb = 1'b1;
                    state_next   = DONE;
`ifdef ALU_MASTER_TIMEOUT_EN
                    timeout_next = 1'b0;
                end else if (count_reg == LIMIT_M1) begin
                    result_next  = '0;
                    timeout_next = 1'b1;
                    state_next   = DONE;
                end else begin
                    count_next   = count_reg + 1'b1;
`endif
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The reset term keeps the flush path in IDLE from popping the FIFO while reset is held.
    assign o_fifo_rx_read = rx_read_comb && !i_reset;
    assign o_req_ready    = (state_reg == IDLE);
    assign o_rsp_valid    = (state_reg == DONE);
    assign o_rsp_result   = result_reg;

endmodule

// File: tb/tb_alu_uart_master.sv
// Directed bench for alu_uart_master: models both UART FIFOs and checks byte order, timing, flushing and reset.
module tb_alu_uart_master;

    logic       i_clk;
    logic       i_reset;
    logic       i_req_valid;
    logic       o_req_ready;
    logic [7:0] i_op_A;
    logic [7:0] i_op_B;
    logic [5:0] i_opcode;
    logic       i_fifo_tx_full;
    logic       o_fifo_tx_write;
    logic [7:0] o_data_to_write;
    logic       i_fifo_rx_empty;
    logic       o_fifo_rx_read;
    logic [7:0] i_data_to_read;
    logic       o_rsp_valid;
    logic [7:0] o_rsp_result;
    logic       o_rsp_timeout;

    alu_uart_master #(
        .NB_DATA      (8),
        .NB_OPCODE    (6),
        .NB_TIMEOUT   (24),
        .TIMEOUT_LIMIT(16)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_op_A         (i_op_A),
        .i_op_B         (i_op_B),
        .i_opcode       (i_opcode),
        .i_fifo_tx_full (i_fifo_tx_full),
        .o_fifo_tx_write(o_fifo_tx_write),
        .o_data_to_write(o_data_to_write),
        .i_fifo_rx_empty(i_fifo_rx_empty),
        .o_fifo_rx_read (o_fifo_rx_read),
        .i_data_to_read (i_data_to_read),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_result   (o_rsp_result),
        .o_rsp_timeout  (o_rsp_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int         total;
    int         bad;
    int         cyc;
    int         acc_cyc;
    int         rsp_cnt;
    int         rsp_cyc;
    int         rx_reads;
    logic [7:0] rsp_res;
    logic       rsp_to;
    logic [7:0] rx_q[$];
    logic [7:0] tx_data_q[$];
    int         tx_cyc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rx();
        i_fifo_rx_empty = (rx_q.size() == 0);
        i_data_to_read  = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_q.push_back(b);
        drive_rx();
    endtask

    task automatic clear_log();
        tx_data_q.delete();
        tx_cyc_q.delete();
        rsp_cnt  = 0;
        rx_reads = 0;
        acc_cyc  = -1;
        rsp_cyc  = -1;
    endtask

    // One clock: observe outputs at the falling edge, apply FIFO pops just after the rising edge.
    task automatic step();
        logic pop;
        @(negedge i_clk);
        chk("tx_write_while_full", 32'(o_fifo_tx_write & i_fifo_tx_full), 32'h0);
        chk("rx_read_while_empty", 32'(o_fifo_rx_read & i_fifo_rx_empty), 32'h0);
        chk("timeout_without_valid", 32'(o_rsp_timeout & ~o_rsp_valid), 32'h0);
        if (o_fifo_tx_write) begin
            tx_data_q.push_back(o_data_to_write);
            tx_cyc_q.push_back(cyc);
        end
        if (o_req_ready && i_req_valid && i_fifo_rx_empty && !i_reset) acc_cyc = cyc;
        if (o_rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            rsp_res = o_rsp_result;
            rsp_to  = o_rsp_timeout;
        end
        pop = o_fifo_rx_read;
        if (pop) rx_reads++;
        @(posedge i_clk);
        #1;
        if (pop && rx_q.size() > 0) void'(rx_q.pop_front());
        drive_rx();
        cyc++;
    endtask

    task automatic send_req(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        i_op_A      = a;
        i_op_B      = b;
        i_opcode    = op;
        i_req_valid = 1'b1;
        step();
        i_req_valid = 1'b0;
    endtask

    task automatic chk_tx(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        chk({tag, "_count"}, 32'(tx_data_q.size()), 32'd3);
        if (tx_data_q.size() == 3) begin
            chk({tag, "_bytes"}, {8'h00, tx_data_q[0], tx_data_q[1], tx_data_q[2]}, {8'h00, a, b, op});
        end
    endtask

    int e_cyc;
    int b_cyc;
    int c_start;

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        rsp_res = 8'h00;
        rsp_to = 1'b0;
        clear_log();
        i_reset = 1'b1;
        i_req_valid = 1'b0;
        i_op_A = 8'h00;
        i_op_B = 8'h00;
        i_opcode = 6'h00;
        i_fifo_tx_full = 1'b0;
        drive_rx();

        // Power-on reset
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_outputs", {26'h0, o_fifo_tx_write, o_fifo_rx_read, o_rsp_valid, o_rsp_timeout, 2'b00}, 32'h0);
        chk("rst_data", {16'h0, o_data_to_write, o_rsp_result}, 32'h0);
        i_reset = 1'b0;
        #1;
        chk("rst_ready_after_release", 32'(o_req_ready), 32'h1);

        // Basic transaction: 5, 3, 0x20 -> result 0x08
        clear_log();
        send_req(8'h05, 8'h03, 6'h20);
        repeat (3) step();
        b_cyc = cyc;
        push_rx(8'h08);
        repeat (3) step();
        chk_tx("t1_tx", 8'h05, 8'h03, 8'h20);
        if (tx_cyc_q.size() == 3) begin
            chk("t1_write_cycles", 32'(tx_cyc_q[0] - acc_cyc), 32'd1);
            chk("t1_consecutive", 32'((tx_cyc_q[2] - tx_cyc_q[1]) * 16 + (tx_cyc_q[1] - tx_cyc_q[0])), 32'h11);
        end
        chk("t1_rsp_count", 32'(rsp_cnt), 32'd1);
        chk("t1_result", 32'(rsp_res), 32'h08);
        chk("t1_latency", 32'(rsp_cyc - b_cyc), 32'd1);
        chk("t1_rx_reads", 32'(rx_reads), 32'd1);
        chk("t1_timeout_flag", 32'(rsp_to), 32'h0);
        chk("t1_result_held", {23'h0, o_rsp_valid, o_rsp_result}, 32'h08);

        // TX FIFO full for 4 cycles while in SEND_B
        clear_log();
        send_req(8'h11, 8'h22, 6'h3F);
        step();
        i_fifo_tx_full = 1'b1;
        repeat (4) step();
        i_fifo_tx_full = 1'b0;
        repeat (2) step();
        chk_tx("t2_tx", 8'h11, 8'h22, 8'h3F);
        if (tx_cyc_q.size() == 3) begin
            chk("t2_b_delay", 32'(tx_cyc_q[1] - tx_cyc_q[0]), 32'd5);
            chk("t2_op_follows_b", 32'(tx_cyc_q[2] - tx_cyc_q[1]), 32'd1);
        end
        push_rx(8'h33);
        repeat (3) step();
        chk("t2_result", {23'h0, 1'(rsp_cnt == 1), rsp_res}, 32'h133);

        // Two stale RX bytes are flushed before the request is accepted
        clear_log();
        push_rx(8'hAA);
        push_rx(8'hBB);
        c_start = cyc;
        i_op_A = 8'h01;
        i_op_B = 8'h02;
        i_opcode = 6'h01;
        i_req_valid = 1'b1;
        repeat (3) step();
        i_req_valid = 1'b0;
        chk("t3_flush_reads", 32'(rx_reads), 32'd2);
        chk("t3_accept_cycle", 32'(acc_cyc - c_start), 32'd2);
        repeat (3) step();
        chk_tx("t3_tx", 8'h01, 8'h02, 8'h01);
        push_rx(8'h03);
        repeat (3) step();
        chk("t3_result", {23'h0, 1'(rsp_cnt == 1), rsp_res}, 32'h103);

`ifdef ALU_MASTER_TIMEOUT_EN
        // No answer: timeout 16 cycles after entering WAIT_RSP
        clear_log();
        send_req(8'h07, 8'h09, 6'h02);
        repeat (3) step();
        e_cyc = cyc;
        repeat (17) step();
        chk("t4_timeout_cycle", 32'(rsp_cyc - e_cyc), 32'd16);
        chk("t4_timeout_rsp", {22'h0, 1'(rsp_cnt == 1), rsp_to, rsp_res}, 32'h300);
        step();

        // Byte on the limit cycle beats the timeout
        clear_log();
        send_req(8'h07, 8'h09, 6'h02);
        repeat (3) step();
        e_cyc = cyc;
        repeat (15) step();
        push_rx(8'h5A);
        repeat (3) step();
        chk("t4_limit_cycle", 32'(rsp_cyc - e_cyc), 32'd16);
        chk("t4_limit_rsp", {22'h0, 1'(rsp_cnt == 1), rsp_to, rsp_res}, 32'h25A);
`else
        // No answer: master keeps waiting indefinitely
        clear_log();
        send_req(8'h07, 8'h09, 6'h02);
        repeat (3) step();
        repeat (40) step();
        chk("t4_still_waiting", {30'h0, 1'(rsp_cnt == 0), o_req_ready}, 32'h2);
        push_rx(8'h5A);
        repeat (3) step();
        chk("t4_late_rsp", {22'h0, 1'(rsp_cnt == 1), rsp_to, rsp_res}, 32'h25A);
`endif

        // Reset in SEND_B, late result byte arrives during reset
        clear_log();
        send_req(8'h44, 8'h55, 6'h04);
        step();
        i_reset = 1'b1;
        push_rx(8'h99);
        #1;
        chk("t5_rst_outputs", {27'h0, o_fifo_tx_write, o_fifo_rx_read, o_rsp_valid, o_rsp_timeout, o_req_ready}, 32'h1);
        chk("t5_rst_data", {16'h0, o_data_to_write, o_rsp_result}, 32'h0);
        step();
        i_reset = 1'b0;
        #1;
        chk("t5_ready_after_release", 32'(o_req_ready), 32'h1);
        chk("t5_tx_before_reset", {24'h0, 8'(tx_data_q.size())}, 32'd1);
        clear_log();
        step();
        chk("t5_late_byte_flushed", {31'h0, 1'(rx_reads == 1 && rx_q.size() == 0)}, 32'h1);
        clear_log();
        send_req(8'h0A, 8'h0B, 6'h0C);
        repeat (3) step();
        chk_tx("t5_tx", 8'h0A, 8'h0B, 8'h0C);
        push_rx(8'h17);
        repeat (3) step();
        chk("t5_result", {23'h0, 1'(rsp_cnt == 1), rsp_res}, 32'h117);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_uart_master.md
ALU_UART_MASTER -- requirements
Module: alu_uart_master

Interface
REQ-001 Parameter NB_DATA, default 8: UART byte width and ALU operand/result width.
REQ-002 Parameter NB_OPCODE, default 6: ALU opcode width, with NB_OPCODE <= NB_DATA.
REQ-003 Parameter NB_TIMEOUT, default 24: response-timeout counter width.
REQ-004 Parameter TIMEOUT_LIMIT, default 10_000_000: clock cycles to wait for a result byte.
REQ-005 Ports i_clk input 1 (sole clock, rising edge) and i_reset input 1 (asynchronous, active-high) SHALL be listed first.
REQ-006 Port i_req_valid input 1: a transaction request is present.
REQ-007 Port o_req_ready output 1: high only in IDLE.
REQ-008 Ports i_op_A and i_op_B, input, NB_DATA each: operands, sampled on request accept.
REQ-009 Port i_opcode input NB_OPCODE: ALU opcode, sampled on request accept.
REQ-010 Ports i_fifo_tx_full input 1, o_fifo_tx_write output 1 and o_data_to_write output NB_DATA: UART TX FIFO write side.
REQ-011 Ports i_fifo_rx_empty input 1, o_fifo_rx_read output 1 and i_data_to_read input NB_DATA: UART RX FIFO read side, head byte visible while not empty.
REQ-012 Ports o_rsp_valid output 1, o_rsp_result output NB_DATA and o_rsp_timeout output 1: response.

Function
REQ-013 FSM states SHALL be IDLE, SEND_A, SEND_B, SEND_OP, WAIT_RSP and DONE.
REQ-014 IDLE: accept when i_req_valid && o_req_ready, register A/B/opcode, go to SEND_A.
REQ-015 IDLE with !i_fifo_rx_empty: pulse o_fifo_rx_read one cycle per stale byte, discarding it; takes priority over request accept.
REQ-016 SEND_x: when !i_fifo_tx_full, assert o_fifo_tx_write one cycle with the byte and advance; otherwise hold with write low.
REQ-017 Byte order on the wire SHALL be A, then B, then opcode zero-extended to NB_DATA.
REQ-018 o_fifo_tx_write SHALL never be asserted while i_fifo_tx_full is high.
REQ-019 With a non-full FIFO, the three writes SHALL occur on 3 consecutive cycles following accept.
REQ-020 WAIT_RSP: when !i_fifo_rx_empty, capture i_data_to_read into o_rsp_result, pulse o_fifo_rx_read one cycle, go to DONE.
REQ-021 DONE: o_rsp_valid high exactly one cycle, then IDLE; o_rsp_result holds until the next response.
REQ-022 Minimum latency SHALL be 1 cycle from result byte visible to o_rsp_valid.
REQ-023 o_fifo_rx_read SHALL never be asserted while i_fifo_rx_empty is high.
REQ-024 A new request SHALL NOT be accepted before DONE is left; one transaction is outstanding at a time.

Reset
REQ-025 Asserting i_reset, including mid-transaction, SHALL force IDLE asynchronously.
REQ-026 During reset SHALL hold: o_fifo_tx_write=0, o_fifo_rx_read=0, o_rsp_valid=0, o_rsp_timeout=0, o_rsp_result=0, o_data_to_write=0, timeout counter=0.
REQ-027 o_req_ready SHALL be 1 on the first cycle after reset release.
REQ-028 Bytes already written to the TX FIFO before reset are not recalled.
REQ-029 A late result byte arriving after reset SHALL be discarded by REQ-015.

Configuration
REQ-030 Macro ALU_MASTER_TIMEOUT_EN defined: the counter clears on WAIT_RSP entry and increments each WAIT_RSP cycle with rx empty.
REQ-031 ALU_MASTER_TIMEOUT_EN defined: on reaching TIMEOUT_LIMIT-1, go to DONE with o_rsp_timeout=1 and o_rsp_result=0.
REQ-032 ALU_MASTER_TIMEOUT_EN defined: a byte arriving on the limit cycle SHALL win over the timeout.
REQ-033 ALU_MASTER_TIMEOUT_EN defined: o_rsp_timeout SHALL be valid only with o_rsp_valid and clear otherwise.
REQ-034 ALU_MASTER_TIMEOUT_EN undefined: no counter, WAIT_RSP waits indefinitely, o_rsp_timeout tied 0.

Verification
REQ-035 A=0x05, B=0x03, opcode=0x20, FIFO not full -> writes 0x05, 0x03, 0x20 on 3 consecutive cycles; RX result 0x08 -> o_rsp_valid one cycle, o_rsp_result=0x08, one rx_read pulse.
REQ-036 i_fifo_tx_full high 4 cycles during SEND_B -> no write while full; B written on the first non-full cycle; byte order intact.
REQ-037 Two stale RX bytes present in IDLE with i_req_valid=1 -> two rx_read pulses, then accept; the response uses only the later byte.
REQ-038 Macro defined, TIMEOUT_LIMIT=16, no RX byte -> o_rsp_valid=1, o_rsp_timeout=1, o_rsp_result=0 sixteen cycles after WAIT_RSP entry; undefined -> stays in WAIT_RSP.
REQ-039 Reset asserted in SEND_B -> outputs zero immediately; o_req_ready=1 after release; next transaction correct.
